// File: rtl/melody_player.sv
// Score-programmable square-wave melody player: steps through a small score RAM at a
// fixed beat rate and sounds each entry as a square-wave tone or a rest.
module melody_player #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 4,
    parameter int DEPTH   = 64,
    parameter int ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int HP_W    = 20
) (
    input  logic              sys_CLK,
    input  logic              sys_RST,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              play,
    input  logic              loop_mode,
    output logic              audio,
    output logic              busy,
    output logic [ADDR_W-1:0] note_idx,
    output logic              done
);
    localparam int TICK_DIV = (CLK_HZ / TICK_HZ > 1) ? CLK_HZ / TICK_HZ : 1;
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [4:0]        PITCH_END = 5'd31;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FETCH, S_PLAY, S_DONE} state_e;

    function automatic logic [HP_W-1:0] hp_of_code(input int code);
        int base_hz;
        int hp;
        case ((code - 1) % 7)
            0:       base_hz = 262;
            1:       base_hz = 294;
            2:       base_hz = 330;
            3:       base_hz = 349;
            4:       base_hz = 392;
            5:       base_hz = 440;
            default: base_hz = 494;
        endcase
        if (code >= 1 && code <= 21) hp = CLK_HZ / (2 * base_hz * (1 << ((code - 1) / 7)));
        else                         hp = 1;
        if (hp < 1) hp = 1;
        return HP_W'(hp);
    endfunction

    // Half periods are elaboration-time constants, one per pitch code.
    logic [HP_W-1:0] hp_rom [32];
    for (genvar g = 0; g < 32; g++) begin : g_hp_rom
        assign hp_rom[g] = hp_of_code(g);
    end

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [4:0]        pitch_q, pitch_d;
    logic [2:0]        dur_q, dur_d;
    logic [HP_W-1:0]   tone_q, tone_d;
    logic              phase_q, phase_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [7:0]        mem_q [DEPTH];
    logic [7:0]        rd_q;
    logic [HP_W-1:0]   hp_cur;
    logic              tick;
    logic              is_tone;

    // NOTE: the score RAM and its read register have no reset so they map onto block RAM;
    // the score survives sys_RST and a same-address read/write returns the old word.
    always_ff @(posedge sys_CLK) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
        if (state_q == S_LOAD) rd_q <= mem_q[addr_q];
    end

    assign hp_cur  = hp_rom[pitch_q];
    assign tick    = (tick_q == TICK_LAST);
    assign is_tone = (pitch_q >= 5'd1) && (pitch_q <= 5'd21);

    always_comb begin
        // NOTE: every _d takes its hold value first, so no path through the case infers a latch.
        state_d = state_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        pitch_d = pitch_q;
        dur_d   = dur_q;
        tone_d  = tone_q;
        phase_d = phase_q;

        case (state_q)
            S_IDLE: begin
                if (play) begin
                    addr_d  = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: state_d = S_FETCH;
            S_FETCH: begin
                if (rd_q[7:3] == PITCH_END) begin
                    if (loop_mode) begin
                        addr_d  = '0;
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    pitch_d = rd_q[7:3];
                    dur_d   = rd_q[2:0];
                    tone_d  = '0;
                    phase_d = 1'b0;
                    idx_d   = addr_q;
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (tone_q == hp_cur - HP_W'(1)) begin
                    tone_d  = '0;
                    phase_d = ~phase_q;
                end else begin
                    tone_d = tone_q + HP_W'(1);
                end
                if (tick) begin
                    if (dur_q != 3'd0) begin
                        dur_d = dur_q - 3'd1;
                    end else if (addr_q != LAST_ADDR) begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = S_LOAD;
                    end else if (loop_mode) begin
                        addr_d  = '0;
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Dropping play aborts from anywhere, ahead of every other transition.
        if (state_q != S_IDLE && !play) state_d = S_IDLE;

        // Beat timing restarts on each LOAD entry, so note length counts from LOAD.
        if (state_d == S_LOAD || state_d == S_IDLE) tick_d = '0;
        else if (tick)                              tick_d = '0;
        else                                        tick_d = tick_q + TICK_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_CLK) begin
        if (sys_RST) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            idx_q   <= '0;
            pitch_q <= '0;
            dur_q   <= '0;
            tone_q  <= '0;
            phase_q <= 1'b0;
            tick_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            pitch_q <= pitch_d;
            dur_q   <= dur_d;
            tone_q  <= tone_d;
            phase_q <= phase_d;
            tick_q  <= tick_d;
        end
    end

    assign audio    = (state_q == S_PLAY) && is_tone && phase_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign note_idx = idx_q;

endmodule
